// File: rtl/dataout_display_ctrl.sv
// dataout_display_ctrl: display-side stage between the core's 32-bit
// dataout export and the four seven-segment nibble decoders.
//
// Ports:
//   clk          in   1  CLOCK_50 domain
//   rst_n        in   1  synchronous, active-low reset
//   data_in      in  32  core dataout export
//   sel_raw      in   1  raw page switch, 1 = upper half-word
//   freeze_n_raw in   1  raw freeze pushbutton, pressed = 0
//   disp_nibbles out 16  [3:0] -> HEX0 ... [15:12] -> HEX3
//   page         out  1  current page, 1 = bits [31:16]
//   hold         out  1  capture frozen
//   changed      out  1  one-cycle pulse on a new captured value
//   flash        out  1  stretched change indicator for an LED
//
// Optional feature: define DISP_AUTO_PAGE_EN to turn sel=1 into an
// automatic page flip every AUTO_PAGE_CYCLES cycles.

module dataout_display_ctrl #(
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int FLASH_CYCLES     = 12500000,
  parameter int AUTO_PAGE_CYCLES = 50000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        sel_raw,
  input  logic        freeze_n_raw,
  output logic [15:0] disp_nibbles,
  output logic        page,
  output logic        hold,
  output logic        changed,
  output logic        flash
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FLW = $clog2(FLASH_CYCLES + 1);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FLW-1:0] FL_LOAD = FLW'(FLASH_CYCLES);

  if (DEBOUNCE_CYCLES < 1 || FLASH_CYCLES < 1 ||
      AUTO_PAGE_CYCLES < 1) begin : g_bad_param
    $error("dataout_display_ctrl: cycle parameters must be >= 1");
  end

  // 2-flop synchronizers
  logic r_sel_s1;
  logic r_sel_s2;
  logic r_frz_s1;
  logic r_frz_s2;

  // debounced values and their stability counters
  logic           r_sel_db;
  logic [DBW-1:0] r_sel_cnt;
  logic           r_frz_db;
  logic           r_frz_db_d;
  logic [DBW-1:0] r_frz_cnt;

  // capture / display path
  logic [31:0]    r_cap;
  logic [15:0]    r_disp;
  logic           r_page;
  logic           r_hold;
  logic           r_changed;
  logic [FLW-1:0] r_fl_cnt;

  logic w_press;
  logic w_new;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel_s1 <= 1'b0;
      r_sel_s2 <= 1'b0;
      r_frz_s1 <= 1'b1;
      r_frz_s2 <= 1'b1;
    end else begin
      r_sel_s1 <= sel_raw;
      r_sel_s2 <= r_sel_s1;
      r_frz_s1 <= freeze_n_raw;
      r_frz_s2 <= r_frz_s1;
    end
  end

  // The counter only runs while the synchronized input disagrees with
  // the accepted value; any return to agreement restarts it, so a
  // glitch shorter than DEBOUNCE_CYCLES never gets through.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sel_db  <= 1'b0;
      r_sel_cnt <= '0;
    end else if (r_sel_s2 == r_sel_db) begin
      r_sel_cnt <= '0;
    end else if (r_sel_cnt == DB_LAST) begin
      r_sel_db  <= r_sel_s2;
      r_sel_cnt <= '0;
    end else begin
      r_sel_cnt <= r_sel_cnt + DBW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frz_db  <= 1'b1;
      r_frz_cnt <= '0;
    end else if (r_frz_s2 == r_frz_db) begin
      r_frz_cnt <= '0;
    end else if (r_frz_cnt == DB_LAST) begin
      r_frz_db  <= r_frz_s2;
      r_frz_cnt <= '0;
    end else begin
      r_frz_cnt <= r_frz_cnt + DBW'(1);
    end
  end

  // falling edge of the debounced active-low button is a press
  assign w_press = r_frz_db_d & ~r_frz_db;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frz_db_d <= 1'b1;
      r_hold     <= 1'b0;
    end else begin
      r_frz_db_d <= r_frz_db;
      if (w_press) begin
        r_hold <= ~r_hold;
      end
    end
  end

  assign w_new = ~r_hold & (data_in != r_cap);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cap     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_changed <= w_new;
      if (!r_hold) begin
        r_cap <= data_in;
      end
    end
  end

  // retriggerable: each change reloads rather than extends
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fl_cnt <= '0;
    end else if (w_new) begin
      r_fl_cnt <= FL_LOAD;
    end else if (r_fl_cnt != '0) begin
      r_fl_cnt <= r_fl_cnt - FLW'(1);
    end
  end

`ifdef DISP_AUTO_PAGE_EN
  localparam int APW = $clog2(AUTO_PAGE_CYCLES + 1);
  localparam logic [APW-1:0] AP_LAST = APW'(AUTO_PAGE_CYCLES - 1);

  logic           r_auto;
  logic [APW-1:0] r_dwell;

  // sel=1 means auto mode; the first cycle in it shows the upper page
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_page  <= 1'b0;
      r_auto  <= 1'b0;
      r_dwell <= '0;
    end else if (!r_sel_db) begin
      r_page  <= 1'b0;
      r_auto  <= 1'b0;
      r_dwell <= '0;
    end else if (!r_auto) begin
      r_page  <= 1'b1;
      r_auto  <= 1'b1;
      r_dwell <= '0;
    end else if (r_dwell == AP_LAST) begin
      r_page  <= ~r_page;
      r_dwell <= '0;
    end else begin
      r_dwell <= r_dwell + APW'(1);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_page <= 1'b0;
    end else begin
      r_page <= r_sel_db;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_disp <= '0;
    end else begin
      r_disp <= r_page ? r_cap[31:16] : r_cap[15:0];
    end
  end

  assign disp_nibbles = r_disp;
  assign page         = r_page;
  assign hold         = r_hold;
  assign changed      = r_changed;
  assign flash        = (r_fl_cnt != '0);

endmodule

// File: tb/tb_dataout_display_ctrl.sv
// Scoreboard bench for dataout_display_ctrl: stimulus queues
// cycle-stamped expectations, a monitor compares them each cycle.

module tb_dataout_display_ctrl;

`ifdef DISP_AUTO_PAGE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  localparam int K_DISP  = 0;
  localparam int K_PAGE  = 1;
  localparam int K_HOLD  = 2;
  localparam int K_CHG   = 3;
  localparam int K_FLASH = 4;

  typedef struct {
    int          at;
    int          kind;
    logic [15:0] val;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic        sel_raw;
  logic        freeze_n_raw;
  logic [15:0] disp_nibbles;
  logic        page;
  logic        hold;
  logic        changed;
  logic        flash;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  dataout_display_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .FLASH_CYCLES    (8),
    .AUTO_PAGE_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .sel_raw     (sel_raw),
    .freeze_n_raw(freeze_n_raw),
    .disp_nibbles(disp_nibbles),
    .page        (page),
    .hold        (hold),
    .changed     (changed),
    .flash       (flash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic ex(input int at, input int k,
                    input logic [15:0] v, input string n);
    exp_t e;
    e.at = at;
    e.kind = k;
    e.val = v;
    e.name = n;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] actual(input int k);
    case (k)
      K_DISP:  return disp_nibbles;
      K_PAGE:  return {15'd0, page};
      K_HOLD:  return {15'd0, hold};
      K_CHG:   return {15'd0, changed};
      default: return {15'd0, flash};
    endcase
  endfunction

  // monitor: samples 2 time units after each rising edge
  initial begin
    logic [15:0] act;
    forever begin
      @(posedge clk);
      #2;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].at <= cyc) begin
          checks++;
          act = actual(q[i].kind);
          if (q[i].at < cyc || act !== q[i].val) begin
            failures++;
            $display("FAIL %s cyc=%0d due=%0d got=%h want=%h",
                     q[i].name, cyc, q[i].at, act, q[i].val);
          end
          q.delete(i);
        end
      end
    end
  end

  initial begin
    int t;
    rst_n        = 1'b0;
    data_in      = 32'hDEADBEEF;
    sel_raw      = 1'b0;
    freeze_n_raw = 1'b1;
    tick(3);

    // reset values, then release
    t = cyc;
    ex(t + 1, K_DISP, 16'h0, "rst_disp");
    ex(t + 1, K_PAGE, 16'h0, "rst_page");
    ex(t + 1, K_HOLD, 16'h0, "rst_hold");
    ex(t + 1, K_CHG, 16'h0, "rst_chg");
    ex(t + 1, K_FLASH, 16'h0, "rst_flash");
    tick(1);
    rst_n = 1'b1;
    ex(t + 2, K_CHG, 16'h1, "rel_chg");
    ex(t + 2, K_FLASH, 16'h1, "rel_flash");
    ex(t + 3, K_DISP, 16'hBEEF, "rel_disp");
    ex(t + 3, K_CHG, 16'h0, "rel_chg_end");
    tick(4);

    // lower page of new value
    t = cyc;
    data_in = 32'h12345678;
    ex(t + 1, K_CHG, 16'h1, "d1_chg");
    ex(t + 2, K_DISP, 16'h5678, "d1_disp");
    tick(4);

    // 3-cycle glitch on sel is rejected
    t = cyc;
    sel_raw = 1'b1;
    tick(3);
    sel_raw = 1'b0;
    ex(t + 10, K_PAGE, 16'h0, "glitch_page");
    ex(t + 10, K_DISP, 16'h5678, "glitch_disp");
    tick(10);

    // real select: 2 sync + 4 debounce + page + disp
    t = cyc;
    sel_raw = 1'b1;
    ex(t + 6, K_PAGE, 16'h0, "sel_page_early");
    ex(t + 7, K_PAGE, 16'h1, "sel_page");
    ex(t + 7, K_DISP, 16'h5678, "sel_disp_early");
    ex(t + 8, K_DISP, 16'h1234, "sel_disp");
    tick(10);
    t = cyc;
    sel_raw = 1'b0;
    ex(t + 6, K_PAGE, 16'h1, "unsel_page_early");
    ex(t + 7, K_PAGE, 16'h0, "unsel_page");
    ex(t + 8, K_DISP, 16'h5678, "unsel_disp");
    tick(10);

    // first press freezes
    t = cyc;
    freeze_n_raw = 1'b0;
    ex(t + 6, K_HOLD, 16'h0, "press1_hold_early");
    ex(t + 7, K_HOLD, 16'h1, "press1_hold");
    tick(8);
    freeze_n_raw = 1'b1;
    tick(8);
    t = cyc;
    data_in = 32'h0000CAFE;
    ex(t + 1, K_CHG, 16'h0, "frozen_chg1");
    ex(t + 2, K_CHG, 16'h0, "frozen_chg2");
    ex(t + 3, K_DISP, 16'h5678, "frozen_disp");
    ex(t + 3, K_HOLD, 16'h1, "release_no_toggle");
    ex(t + 3, K_FLASH, 16'h0, "frozen_flash");
    tick(4);

    // second press unfreezes and picks up the new value
    t = cyc;
    freeze_n_raw = 1'b0;
    ex(t + 6, K_HOLD, 16'h1, "press2_hold_early");
    ex(t + 7, K_HOLD, 16'h0, "press2_hold");
    ex(t + 7, K_CHG, 16'h0, "press2_chg_early");
    ex(t + 8, K_CHG, 16'h1, "press2_chg");
    ex(t + 9, K_DISP, 16'hCAFE, "press2_disp");
    ex(t + 9, K_CHG, 16'h0, "press2_chg_end");
    tick(8);
    freeze_n_raw = 1'b1;
    tick(12);

    // single change: flash exactly 8 cycles
    t = cyc;
    data_in = 32'h0000BEEF;
    ex(t + 1, K_CHG, 16'h1, "f1_chg");
    ex(t + 2, K_CHG, 16'h0, "f1_chg_end");
    ex(t + 1, K_FLASH, 16'h1, "f1_first");
    ex(t + 8, K_FLASH, 16'h1, "f1_last");
    ex(t + 9, K_FLASH, 16'h0, "f1_off");
    tick(12);

    // retrigger 5 cycles later: 13 cycles total
    t = cyc;
    data_in = 32'h11112222;
    ex(t + 1, K_CHG, 16'h1, "f2_chg_a");
    ex(t + 5, K_FLASH, 16'h1, "f2_mid");
    ex(t + 5, K_CHG, 16'h0, "f2_no_chg");
    ex(t + 6, K_CHG, 16'h1, "f2_chg_b");
    ex(t + 7, K_DISP, 16'h4444, "f2_disp");
    ex(t + 13, K_FLASH, 16'h1, "f2_last");
    ex(t + 14, K_FLASH, 16'h0, "f2_off");
    tick(5);
    data_in = 32'h33334444;
    tick(20);

    // reset mid-flash and mid-debounce
    t = cyc;
    data_in = 32'h55556666;
    sel_raw = 1'b1;
    ex(t + 4, K_FLASH, 16'h1, "mid_flash_on");
    ex(t + 5, K_FLASH, 16'h0, "mid_rst_flash");
    ex(t + 5, K_PAGE, 16'h0, "mid_rst_page");
    ex(t + 5, K_CHG, 16'h0, "mid_rst_chg");
    ex(t + 5, K_DISP, 16'h0, "mid_rst_disp");
    ex(t + 6, K_CHG, 16'h1, "post_rst_chg");
    ex(t + 7, K_DISP, 16'h6666, "post_rst_disp");
    ex(t + 11, K_PAGE, 16'h0, "post_rst_page_early");
    ex(t + 12, K_PAGE, 16'h1, "post_rst_page");
    ex(t + 13, K_DISP, 16'h5555, "post_rst_upper");
    ex(t + 27, K_PAGE, 16'h1, "dwell_before");
    ex(t + 28, K_PAGE, AUTO ? 16'h0 : 16'h1, "dwell_flip1");
    ex(t + 44, K_PAGE, 16'h1, "dwell_flip2");
    ex(t + 51, K_PAGE, 16'h1, "off_page_early");
    ex(t + 52, K_PAGE, 16'h0, "off_page");
    tick(4);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(40);
    sel_raw = 1'b0;
    tick(12);

    tick(4);
    if (q.size() != 0) begin
      checks += q.size();
      failures += q.size();
      $display("FAIL pending_expectations left=%0d", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
